dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Data-memory responder that sits on the far end of the CPU's load/store port. It replaces the single-cycle DM with a handshaked, fixed-latency slave, so that multi-cycle and pipelined cores can stall on memory. The block accepts one request at a time over a valid/ready channel. It performs a word access with byte enables and returns a response over a second valid/ready channel.

Parameters:
DEPTH_LOG2, 10, log2 of word count (1024 x 32-bit words, byte range 0x0000-0x0FFF)
LATENCY, 2, cycles from request accept edge to rsp_valid high; legal range 1..15

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low; clears state and memory
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i writes byte lane i (bits 8i+7:8i)
req_pc  input  32  PC of the issuing instruction, used only for the trace
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes the response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - Every memory word is cleared to 0.
  - Reset applied in any state aborts the transaction; a store not yet committed is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N, latch we/addr/wdata/be/pc, load counter with LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter!=0, decrement it.
  - If counter==0, perform the access at this edge, drive rsp_* and go to RESP.
  - rsp_valid therefore rises after edge N+LATENCY. With LATENCY=1 this is the edge after accept.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready at an edge, clear rsp_valid and go to IDLE.
  - req_ready returns to 1 in the cycle after the handshake. No request is accepted in the same cycle as the response handshake, so back-to-back throughput is one request per LATENCY+2 cycles.
- Error check (at commit):
  - err = (addr[1:0]!=0) || (addr[31:DEPTH_LOG2+2]!=0).
  - On error: no memory change, rsp_rdata=0, rsp_err=1.
- Word index = addr[DEPTH_LOG2+1:2].
- Store:
  - For each lane i with be[i]=1, mem[idx] byte i <= wdata byte i; lanes with be[i]=0 keep their old value.
  - be=0000 is legal: no change, response still returned.
  - rsp_rdata=0.
- Load: rsp_rdata = full word mem[idx] as it stands at commit; be is ignored.
- The memory is written only at the commit edge. Inputs that change after accept have no effect.
- The responder ignores req_valid outside IDLE. The initiator must hold the request until req_ready is seen.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined:
  - At each successful store commit, $display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word).
  - merged_word is the full 32-bit word after the byte-enable merge.
  - Nothing is printed for loads, errors, or while reset==0.
- Undefined:
  - No $display is emitted and req_pc is unused.
  - Functional behaviour is identical.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, load of 0x0000 returns rdata=0x00000000, err=0.
- Full store then load, LATENCY=2:
  - Store addr=0x0010, wdata=0x12345678, be=1111 accepted at edge N -> rsp_valid high after edge N+2, rdata=0.
  - A following load of 0x0010 returns 0x12345678.
- Byte-lane merge:
  - Over word 0x12345678 at 0x0010, store wdata=0xAABBCCDD with be=0101 -> load returns 0x12BB56DD.
  - With DM_TRACE_EN: "@<pc>: *00000010 <= 12bb56dd".
- Errors:
  - Load at 0x0013 -> rsp_err=1, rdata=0.
  - Store at 0x1000 (DEPTH_LOG2=10) -> rsp_err=1, and memory word 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles with rsp_valid high -> rdata and err stable, req_ready=0, a new req_valid is ignored; after rsp_ready=1, the block returns to IDLE the next cycle.
- Reset mid-WAIT, LATENCY=4: store 0xDEADBEEF to 0x0020, assert reset one cycle after accept -> state IDLE, rsp_valid=0, and a later load of 0x0020 returns 0.

Source files
------------

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Data-memory responder for the far end of a CPU load/store port. One request
// is accepted at a time on a valid/ready channel. The word access with byte
// enables is committed LATENCY edges after the accept edge, and the result is
// returned on a second valid/ready channel.
//
// Optional build macro: DM_TRACE_EN. When it is defined, every successful
// store commit prints "@<pc>: *<word addr> <= <merged word>".
//
// Parameters
//   DEPTH_LOG2  log2 of the number of 32-bit words (default 1024 words)
//   LATENCY     accept edge to rsp_valid_o edge, 1..15
//
// Ports
//   clk          clock; all state updates on posedge
//   reset        synchronous, active-low; clears FSM, response and memory
//   req_valid_i  request present
//   req_ready_o  responder can accept a request (IDLE only)
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address
//   req_wdata_i  store data
//   req_be_i     byte enables, bit i covers bits 8i+7:8i
//   req_pc_i     PC of the issuing instruction (trace only)
//   rsp_valid_o  response present
//   rsp_ready_i  consumer takes the response
//   rsp_rdata_o  load data; 0 for stores and errors
//   rsp_err_o    request was misaligned or out of range
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_pc_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte-lane merge of new store data over the old memory word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] pc_q, pc_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [0:DEPTH-1];

    logic                  commit_s;
    logic                  err_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [31:0]           old_word_s;
    logic [31:0]           merged_s;

    // Access decode works only on the latched request, so input changes after
    // accept cannot influence the commit.
    assign commit_s   = (state_q == WAIT) && (cnt_q == 4'd0);
    assign err_s      = (addr_q[1:0] != 2'b00) || (addr_q[31:DEPTH_LOG2+2] != '0);
    assign idx_s      = addr_q[DEPTH_LOG2+1:2];
    assign old_word_s = mem_q[idx_s];
    assign merged_s   = merge_bytes(old_word_s, wdata_q, be_q);

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // Next-state and output logic for the IDLE/WAIT/RESP handshake FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        pc_d        = pc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    pc_d    = req_pc_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    rsp_rdata_d = (err_s || we_q) ? 32'h0000_0000 : old_word_s;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        // Ready is registered: it rises the cycle after the response handshake.
        req_ready_d = (state_d == IDLE);
    end

    // FSM, latched request and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            be_q        <= 4'b0000;
            pc_q        <= 32'h0000_0000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            pc_q        <= pc_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array: cleared by reset, written only at a valid store commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            if (commit_s && we_q && !err_s) begin
                mem_q[idx_s] <= merged_s;
`ifdef DM_TRACE_EN
                $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged_s);
`endif
            end
        end
    end

`ifndef DM_TRACE_EN
    // The PC only feeds the trace; keep it visibly consumed in plain builds.
    logic unused_pc_s;
    assign unused_pc_s = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset2, reset4;
    logic        valid2, valid4;
    logic        we;
    logic [31:0] addr, wdata, pc;
    logic [3:0]  be;
    logic        rsp_ready;

    logic        rdy2, rv2, er2;
    logic [31:0] rd2;
    logic        rdy4, rv4, er4;
    logic [31:0] rd4;

    int n_cmp = 0;
    int n_bad = 0;

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset2),
        .req_valid_i(valid2), .req_ready_o(rdy2), .req_we_i(we),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .req_pc_i(pc),
        .rsp_valid_o(rv2), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rd2), .rsp_err_o(er2)
    );

    dm_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset4),
        .req_valid_i(valid4), .req_ready_o(rdy4), .req_we_i(we),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .req_pc_i(pc),
        .rsp_valid_o(rv4), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rd4), .rsp_err_o(er4)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input bit sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rdata, output logic err);
        int cyc;
        we = w; addr = a; wdata = d; be = b; pc = 32'h0000_0400 + a;
        cyc = 0;
        while (!(sel ? rdy4 : rdy2) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("req_ready_seen", {31'b0, (sel ? rdy4 : rdy2)}, 32'd1);
        if (sel) valid4 = 1'b1; else valid2 = 1'b1;
        @(posedge clk); #1;
        valid2 = 1'b0; valid4 = 1'b0;
        cyc = 0;
        while (!(sel ? rv4 : rv2) && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("latency", cyc, sel ? 32'd4 : 32'd2);
        rdata = sel ? rd4 : rd2;
        err   = sel ? er4 : er2;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'b0, (sel ? rv4 : rv2)}, 32'd0);
        chk("req_ready_back", {31'b0, (sel ? rdy4 : rdy2)}, 32'd1);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'h12BB_56DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         4'b1111, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h1122_3344, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h12BB_56DD, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'b1000, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'hCA00_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 32'h0000_0002, 32'h0,         4'b0000, 32'h0000_0000, 1'b1};
        vecs[16] = '{1'b1, 32'h0000_0004, 32'h5A5A_5A5A, 4'b0011, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h0000_5A5A, 1'b0};

        reset2 = 1'b0; reset4 = 1'b0;
        valid2 = 1'b0; valid4 = 1'b0; rsp_ready = 1'b0;
        we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset2 = 1'b1; reset4 = 1'b1;

        chk("reset_req_ready", {31'b0, rdy2}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rv2}, 32'd0);
        chk("reset_rdata", rd2, 32'h0);
        chk("reset_err", {31'b0, er2}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            do_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata, err);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
        end

        // Backpressure: response held 5 cycles while a new request is offered.
        we = 1'b0; addr = 32'h0000_0010; be = 4'b1111;
        valid2 = 1'b1;
        @(posedge clk); #1;
        valid2 = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!rv2 && cyc < 40) begin
                @(posedge clk); #1; cyc++;
            end
            chk("bp_latency", cyc, 32'd2);
        end
        we = 1'b1; addr = 32'h0000_0010; wdata = 32'hFFFF_FFFF; be = 4'b1111;
        valid2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'b0, rv2}, 32'd1);
            chk("bp_rdata", rd2, 32'h12BB_56DD);
            chk("bp_err", {31'b0, er2}, 32'd0);
            chk("bp_req_ready", {31'b0, rdy2}, 32'd0);
        end
        valid2 = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_release_valid", {31'b0, rv2}, 32'd0);
        chk("bp_release_ready", {31'b0, rdy2}, 32'd1);
        do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, rdata, err);
        chk("bp_ignored_store", rdata, 32'h12BB_56DD);

        // Reset clears memory contents.
        reset2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset2 = 1'b1;
        do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, rdata, err);
        chk("mem_cleared", rdata, 32'h0);

        // Reset mid-WAIT on the LATENCY=4 instance aborts the store.
        we = 1'b1; addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF; be = 4'b1111;
        chk("l4_ready", {31'b0, rdy4}, 32'd1);
        valid4 = 1'b1;
        @(posedge clk); #1;
        valid4 = 1'b0;
        @(posedge clk); #1;
        chk("l4_in_wait", {31'b0, rdy4}, 32'd0);
        reset4 = 1'b0;
        @(posedge clk); #1;
        reset4 = 1'b1;
        chk("l4_abort_valid", {31'b0, rv4}, 32'd0);
        chk("l4_abort_ready", {31'b0, rdy4}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("l4_no_late_rsp", {31'b0, rv4}, 32'd0);
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, rdata, err);
        chk("l4_store_aborted", rdata, 32'h0);
        chk("l4_load_err", {31'b0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
